spram_access_arbiter: RTL
=========================

// Module: spram_access_arbiter
// PURPOSE
// - Sits directly upstream of the single-port RAM (spram) and owns its address/data/wren/q pins.
// - Time-multiplexes a CPU port and a video-scan read port onto the RAM at one access per clock,
//   fully pipelined.
// - Video reads have priority; a wait-limit guarantees CPU forward progress.
// - Returns read data to whichever requester issued the read.
// PARAMETERS
// - widthad_a     15    RAM address width; must match the spram instance.
// - DATA_WIDTH    8     RAM data width; must match the spram instance.
// - CPU_MAX_WAIT  4     Max cycles a pending CPU request may be refused before it pre-empts video.
//                       Range 1..255.
// - CLEAR_VALUE   0     Fill value written by the optional clear sweep.
// PORTS
// - clock        in   1           System clock; all logic on rising edge.
// - reset        in   1           Synchronous, active-high reset.
// - cpu_req      in   1           CPU request; level, held until cpu_ack.
// - cpu_we       in   1           1 = write, 0 = read; stable while cpu_req is high.
// - cpu_addr     in   widthad_a   CPU address; stable while cpu_req is high.
// - cpu_wdata    in   DATA_WIDTH  CPU write data.
// - cpu_ack      out  1           One-cycle completion pulse.
// - cpu_rdata    out  DATA_WIDTH  CPU read data; valid while cpu_ack=1 for a read.
// - vid_req      in   1           Video read strobe; may be high every cycle.
// - vid_addr     in   widthad_a   Video read address.
// - vid_valid    out  1           One-cycle pulse; vid_rdata valid.
// - vid_rdata    out  DATA_WIDTH  Video read data.
// - vid_miss     out  1           One-cycle pulse; a vid_req was dropped.
// - busy         out  1           Clear sweep in progress.
// - mem_address  out  widthad_a   To spram address (registered).
// - mem_data     out  DATA_WIDTH  To spram data (registered).
// - mem_wren     out  1           To spram wren (registered).
// - mem_q        in   DATA_WIDTH  From spram q.
// BEHAVIOUR
// - Reset values: all mem_*, cpu_ack, cpu_rdata, vid_valid, vid_rdata, vid_miss = 0; cpu_wait = 0.
//   busy = 1 if CLEAR_ON_RESET_EN is defined, else 0.
// - Reset mid-operation: in-flight reads are discarded and no ack/valid is issued for them.
// - Grant at edge N: requests are sampled and mem_* are registered at edge N.
//   The spram acts at edge N+1.
// - Video read: vid_valid=1 and vid_rdata=mem_q are registered at edge N+2. Latency is 2 cycles.
// - CPU read: cpu_ack=1 and cpu_rdata are registered at edge N+2.
// - CPU write: cpu_ack=1 is registered at edge N+1; cpu_rdata is unchanged.
// - A 2-deep tag pipe (valid, owner) routes mem_q to the correct requester.
//   Back-to-back grants are all serviced.
// - CPU in flight: from its grant until its cpu_ack cycle ends, cpu_req is not re-sampled.
//   cpu_req still high in the cycle after the ack is a new request.
// - Priority, evaluated each edge when busy=0:
//   - vid_req and no pending CPU: grant video.
//   - vid_req and pending CPU with cpu_wait < CPU_MAX_WAIT: grant video; cpu_wait++.
//   - vid_req and pending CPU with cpu_wait == CPU_MAX_WAIT: grant CPU; drop video; vid_miss=1;
//     cpu_wait = 0.
//   - No vid_req and pending CPU: grant CPU; cpu_wait = 0.
//   - Neither: mem_wren=0; mem_address holds its last value.
// - cpu_wait saturates at CPU_MAX_WAIT and clears on every CPU grant.
// - mem_wren=1 only for the cycle following a CPU-write grant or a clear step.
// CONFIGURATION
// - Macro CLEAR_ON_RESET_EN.
// - Defined: after reset the block is in state CLEAR with busy=1.
//   - Writes CLEAR_VALUE to addresses 0..2^widthad_a-1, one per cycle.
//   - After the last address it enters RUN with busy=0; the sweep takes 2^widthad_a cycles.
//   - During CLEAR, each vid_req gives vid_miss=1 with no vid_valid.
//     cpu_req stays pending with no ack and cpu_wait does not count.
//   - Reset during CLEAR restarts the sweep at address 0.
// - Undefined: no CLEAR state; busy is tied to 0; RUN starts the first cycle after reset.
// TESTING
// - CPU write 0x5A to 0x0123, then CPU read of 0x0123.
//   -> write ack 1 cycle after grant; read ack 2 cycles after grant with cpu_rdata=0x5A.
// - vid_req every cycle for 8 cycles, addresses 0..7 preloaded with addr+0x10.
//   -> 8 consecutive vid_valid pulses, data 0x10..0x17 in order, 2-cycle latency.
// - CPU_MAX_WAIT=4, vid_req held high, CPU read pending.
//   -> CPU granted on the 5th cycle, exactly one vid_miss pulse, cpu_ack 2 cycles later.
// - vid_req and CPU request in the same idle cycle with cpu_wait=0.
//   -> video granted first, CPU granted the next cycle.
// - Reset asserted with two reads in flight.
//   -> no vid_valid or cpu_ack afterwards; all outputs 0 the cycle after reset.
// - With CLEAR_ON_RESET_EN, widthad_a=4, CLEAR_VALUE=0xFF.
//   -> busy=1 for 16 cycles; vid_req during the sweep gives vid_miss; all 16 reads return 0xFF.

Source files
------------

// File: rtl/spram_access_arbiter.sv
// spram_access_arbiter
// Owns the pins of one single-port RAM. It shares the RAM between a CPU
// read/write port and a video-scan read port at one access per clock.
// Video reads normally win. A wait counter makes sure a starved CPU request
// eventually pre-empts video.
// Optional feature macro: CLEAR_ON_RESET_EN. When it is defined, every reset
// starts a sweep that writes CLEAR_VALUE to the whole RAM. Normal arbitration
// begins once the sweep finishes.
module spram_access_arbiter #(
    parameter int                    widthad_a    = 15,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    CPU_MAX_WAIT = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [widthad_a-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [widthad_a-1:0]  vid_addr,
    output logic                  vid_valid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  vid_miss,
    output logic                  busy,
    output logic [widthad_a-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

    logic                 running;
    logic                 clear_step;
    logic [widthad_a-1:0] clear_addr;

    logic       cpu_inflight;
    logic       cpu_pending;
    logic       grant_cpu;
    logic       grant_vid;
    logic       drop_vid;
    logic [7:0] cpu_wait;

    logic tag1_valid, tag1_cpu, tag1_we;
    logic tag2_valid, tag2_cpu, tag2_we;

`ifdef CLEAR_ON_RESET_EN
    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic [widthad_a-1:0] clear_addr_next;

    // State register and sweep address; reset always restarts the sweep at address 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            clear_addr <= '0;
        end else begin
            state      <= state_next;
            clear_addr <= clear_addr_next;
        end
    end

    // Sweep one address per cycle and hand over to RUN after the last address
    always_comb begin
        state_next      = state;
        clear_addr_next = clear_addr;
        if (state == CLEAR) begin
            clear_addr_next = clear_addr + widthad_a'(1);
            if (clear_addr == '1) begin
                state_next = RUN;
            end
        end
    end

    assign running    = (state == RUN);
    assign clear_step = (state == CLEAR);
    assign busy       = (state == CLEAR);
`else
    // Without the clear feature, the sweep datapath below is simply never selected
    assign running    = 1'b1;
    assign clear_step = 1'b0;
    assign clear_addr = '0;
    assign busy       = 1'b0;
`endif

    // Pick the requester for this edge; a CPU access is not re-sampled until its ack cycle ends
    always_comb begin
        cpu_inflight = (tag1_valid && tag1_cpu) || (tag2_valid && tag2_cpu) || cpu_ack;
        cpu_pending  = cpu_req && !cpu_inflight;
        grant_cpu    = 1'b0;
        grant_vid    = 1'b0;
        drop_vid     = 1'b0;
        if (running) begin
            if (vid_req && cpu_pending && (cpu_wait >= MAX_WAIT)) begin
                grant_cpu = 1'b1;
                drop_vid  = 1'b1;
            end else if (vid_req) begin
                grant_vid = 1'b1;
            end else if (cpu_pending) begin
                grant_cpu = 1'b1;
            end
        end
    end

    // Drive the RAM pins and track how long a pending CPU request has been refused
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            cpu_wait    <= '0;
        end else begin
            mem_wren <= 1'b0;
            if (clear_step) begin
                mem_address <= clear_addr;
                mem_data    <= CLEAR_VALUE;
                mem_wren    <= 1'b1;
            end else if (grant_cpu) begin
                mem_address <= cpu_addr;
                mem_data    <= cpu_wdata;
                mem_wren    <= cpu_we;
                cpu_wait    <= '0;
            end else if (grant_vid) begin
                mem_address <= vid_addr;
                if (cpu_pending && (cpu_wait < MAX_WAIT)) begin
                    cpu_wait <= cpu_wait + 8'd1;
                end
            end
        end
    end

    // Two-stage tag pipe that steers mem_q back to the requester that issued the read
    always_ff @(posedge clock) begin
        if (reset) begin
            tag1_valid <= 1'b0;
            tag1_cpu   <= 1'b0;
            tag1_we    <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_cpu   <= 1'b0;
            tag2_we    <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_valid  <= 1'b0;
            vid_rdata  <= '0;
            vid_miss   <= 1'b0;
        end else begin
            tag1_valid <= grant_cpu || grant_vid;
            tag1_cpu   <= grant_cpu;
            tag1_we    <= grant_cpu && cpu_we;
            tag2_valid <= tag1_valid;
            tag2_cpu   <= tag1_cpu;
            tag2_we    <= tag1_we;
            cpu_ack    <= (tag1_valid && tag1_cpu && tag1_we) ||
                          (tag2_valid && tag2_cpu && !tag2_we);
            vid_valid  <= tag2_valid && !tag2_cpu;
            vid_miss   <= drop_vid || (clear_step && vid_req);
            if (tag2_valid && !tag2_we) begin
                if (tag2_cpu) begin
                    cpu_rdata <= mem_q;
                end else begin
                    vid_rdata <= mem_q;
                end
            end
        end
    end

endmodule
